apb_slave_regs: RTL and testbench
=================================

// Module: apb_slave_regs
// PURPOSE
//  APB completer at the far end of master_bridge: responds to PSELx/penable/pwrite/paddr/pwdata with
//  pready/prdata/pslverr. Holds a small word-addressed register file with a programmable number of
//  wait states. One instance hangs off PSEL1, a second off PSEL2. It is also the bench target for the bridge.
// PARAMETERS
//  ADDR_W       32  width of paddr; only the low bits are decoded
//  DATA_W       32  width of pwdata/prdata
//  DEPTH        16  number of 32-bit registers, power of 2; word index = paddr[log2(DEPTH)+1:2]
//  WAIT_STATES   0  extra access cycles with pready low before pready high (0..15)
// PORTS
//  pclk      in   1       APB clock; all logic on rising edge
//  Reset     in   1       synchronous, active-high reset
//  psel      in   1       slave select from bridge (PSEL1 or PSEL2)
//  penable   in   1       access-phase strobe
//  pwrite    in   1       1 = write, 0 = read
//  paddr     in   ADDR_W  byte address
//  pwdata    in   DATA_W  write data
//  pready    out  1       transfer complete this cycle
//  prdata    out  DATA_W  read data, valid when pready=1 and pwrite=0
//  pslverr   out  1       error response, valid only when pready=1
// BEHAVIOUR
//  - One clock (pclk); reset is synchronous and active-high (Reset). Reset: state=IDLE, pready=0,
//    prdata=0, pslverr=0, wait counter=0, all DEPTH registers=0. Reset mid-transfer aborts it and drops
//    any pending write.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, WAIT, ACCESS.
//    IDLE: an edge sampling psel=1,penable=0 (setup phase) latches paddr/pwrite/pwdata and decodes.
//          WAIT_STATES=0 -> ACCESS with pready<=1; otherwise WAIT with cnt<=WAIT_STATES-1.
//          penable=1 without a preceding setup is ignored.
//    WAIT: cnt decrements each edge; when cnt==0 -> ACCESS, pready<=1.
//          If psel is sampled 0, abort: go to IDLE, no write, pready stays 0.
//    ACCESS: pready=1 for exactly one cycle. The completion edge samples psel&penable&pready.
//          The write commits on that edge; then pready<=0, pslverr<=0 and the FSM returns to IDLE.
//          If psel=0, return to IDLE without a write.
//  - Latency: pready is high in access cycle WAIT_STATES+1. A zero-wait transfer is 2 cycles (setup+access).
//    Back-to-back: the next setup follows the completion cycle and is accepted by IDLE.
//  - Decode errors (pslverr=1 with pready): paddr[1:0]!=0, or paddr bits above the index field
//    (up to ADDR_W-1) are nonzero. An errored write never modifies a register; an errored read
//    returns prdata=0.
//  - prdata is loaded on the edge that raises pready for a valid read and holds until the next read
//    completes; writes do not change prdata.
//  - Read-after-write to the same address in consecutive transfers returns the new data.
//  - Address and data are the values latched at setup; changes during WAIT are ignored.
// STRUCTURE
//  - Shared package apb_pkg: state encoding (IDLE/WAIT/ACCESS), APB_ADDR_W=32, APB_DATA_W=32.
//    master_bridge uses the same constants.
//  - One sub-module, apb_wait_ctr: loadable down-counter with a zero flag.
//  - The register file is an inline array in this module.
// TESTING
//  - Reset held 2 cycles -> pready=0, prdata=0, pslverr=0; a read of 0x0 then returns 0x00000000.
//  - WAIT_STATES=0: write 0x01234567 @0x4 -> pready high in the first access cycle, pslverr=0;
//    read @0x4 -> prdata=0x01234567.
//  - WAIT_STATES=3: read @0x4 -> pready low for 3 access cycles, high on the 4th, data correct.
//    Abort by dropping psel in WAIT -> no pready.
//  - Errors: write 0xDEADBEEF @0x6 (misaligned), then @0x40 (out of range, DEPTH=16) -> pslverr=1;
//    register 0x4 is unchanged.
//  - Back-to-back: write 0x89ABCDEF @0x8, then read @0x8 -> 0x89ABCDEF, no idle cycle required.
//  - Assert Reset during ACCESS of a write @0xC -> write lost; read @0xC after reset returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB constants and FSM state encoding for the completer and master_bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between one requester (bridge) and one completer.
interface apb_slave_regs_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with a registered zero flag, used to pace APB wait states.
module apb_wait_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic         zero_q;

    // Zero flag is tracked alongside the count so it is available straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (dec_i && !zero_q) begin
            cnt_q  <= cnt_q - W'(1);
            zero_q <= (cnt_q == W'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with a word-addressed register file and a fixed number of wait states.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             pclk,
    input  logic             Reset,
    apb_slave_regs_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = WAIT_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    apb_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              setup_c;
    logic [IDX_W-1:0]  in_idx_c;
    logic              in_err_c;
    logic              cnt_load_c;
    logic              cnt_dec_c;
    logic              cnt_zero;

    // Decode of the live bus address; only used on the setup edge.
    assign setup_c    = (state_q == IDLE) && bus.psel && !bus.penable;
    assign in_idx_c   = bus.paddr[IDX_W+1:2];
    assign in_err_c   = (bus.paddr[1:0] != 2'b00) || ((bus.paddr >> (IDX_W + 2)) != '0);
    assign cnt_load_c = setup_c && (WAIT_STATES != 0);
    assign cnt_dec_c  = (state_q == WAIT) && bus.psel;

    apb_wait_ctr #(
        .W (CNT_W)
    ) u_wait_ctr (
        .clk        (pclk),
        .rst        (Reset),
        .load_i     (cnt_load_c),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec_c),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup_c) begin
                        idx_q   <= in_idx_c;
                        write_q <= bus.pwrite;
                        err_q   <= in_err_c;
                        wdata_q <= bus.pwdata;
                        if (WAIT_STATES == 0) begin
                            state_q   <= ACCESS;
                            pready_q  <= 1'b1;
                            pslverr_q <= in_err_c;
                            if (!bus.pwrite) begin
                                prdata_q <= in_err_c ? '0 : regs_q[in_idx_c];
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Dropping psel mid-wait abandons the transfer silently.
                    if (!bus.psel) begin
                        state_q <= IDLE;
                    end else if (cnt_zero) begin
                        state_q   <= ACCESS;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        if (!write_q) begin
                            prdata_q <= err_q ? '0 : regs_q[idx_q];
                        end
                    end
                end
                ACCESS: begin
                    if (bus.psel && bus.penable && pready_q && write_q && !err_q) begin
                        regs_q[idx_q] <= wdata_q;
                    end
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed scoreboard bench: a zero-wait and a three-wait completer driven from one sequence.
module tb_apb_slave_regs;

    logic pclk = 1'b0;
    logic rst;

    always #5 pclk = ~pclk;

    apb_slave_regs_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_slave_regs_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    apb_slave_regs #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .pclk  (pclk),
        .Reset (rst),
        .bus   (bus0.slave)
    );

    apb_slave_regs #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .pclk  (pclk),
        .Reset (rst),
        .bus   (bus3.slave)
    );

    typedef struct {
        string       tag;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem0 [16];
    logic [31:0] mem3 [16];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int tgt, input logic sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        bus0.psel    = (tgt == 0) && sel;
        bus3.psel    = (tgt == 3) && sel;
        bus0.penable = en;
        bus3.penable = en;
        bus0.pwrite  = wr;
        bus3.pwrite  = wr;
        bus0.paddr   = a;
        bus3.paddr   = a;
        bus0.pwdata  = d;
        bus3.pwdata  = d;
    endtask

    function automatic logic rdy(input int tgt);
        return (tgt == 0) ? bus0.pready : bus3.pready;
    endfunction

    function automatic logic [31:0] rdat(input int tgt);
        return (tgt == 0) ? bus0.prdata : bus3.prdata;
    endfunction

    function automatic logic serr(input int tgt);
        return (tgt == 0) ? bus0.pslverr : bus3.pslverr;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 32'h0;
            mem3[i] = 32'h0;
        end
    endtask

    // One complete transfer; expectation is queued at setup and retired when pready shows.
    task automatic xfer(input int tgt, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
        exp_t e;
        int   n;
        int   idx;
        logic err;
        err      = (addr[1:0] != 2'b00) || (addr >= 32'h40);
        idx      = int'(addr[5:2]);
        e.tag    = tag;
        e.chk_rd = !wr;
        e.err    = err;
        e.lat    = (tgt == 0) ? 1 : 4;
        e.rdata  = err ? 32'h0 : ((tgt == 0) ? mem0[idx] : mem3[idx]);
        sb.push_back(e);
        drive(tgt, 1'b1, 1'b0, wr, addr, wd);
        @(negedge pclk);
        drive(tgt, 1'b1, 1'b1, wr, addr, wd);
        n = 1;
        while (!rdy(tgt) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        e = sb.pop_front();
        if (!rdy(tgt)) begin
            chk({e.tag, "_timeout"}, 32'(rdy(tgt)), 32'h1);
        end else begin
            chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
            chk({e.tag, "_err"}, 32'(serr(tgt)), 32'(e.err));
            if (e.chk_rd) chk({e.tag, "_rdata"}, rdat(tgt), e.rdata);
            if (wr && !err) begin
                if (tgt == 0) mem0[idx] = wd;
                else          mem3[idx] = wd;
            end
        end
        @(negedge pclk);
        drive(tgt, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy0"},  32'(bus0.pready),  32'h0);
        chk({tag, "_err0"},  32'(bus0.pslverr), 32'h0);
        chk({tag, "_data0"}, bus0.prdata,       32'h0);
        chk({tag, "_rdy3"},  32'(bus3.pready),  32'h0);
        chk({tag, "_err3"},  32'(bus3.pslverr), 32'h0);
        chk({tag, "_data3"}, bus3.prdata,       32'h0);
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("reset");
        rst = 1'b0;

        xfer(0, 1'b0, 32'h0, 32'h0, "rd0_ws0");
        xfer(0, 1'b1, 32'h4, 32'h01234567, "wr4_ws0");
        xfer(0, 1'b0, 32'h4, 32'h0, "rd4_ws0");

        xfer(3, 1'b0, 32'h4, 32'h0, "rd4_ws3_empty");
        xfer(3, 1'b1, 32'h4, 32'hCAFEF00D, "wr4_ws3");
        xfer(3, 1'b0, 32'h4, 32'h0, "rd4_ws3");

        // Abort a wait-state write by dropping psel; nothing may complete or commit.
        drive(3, 1'b1, 1'b0, 1'b1, 32'h10, 32'h55555555);
        @(negedge pclk);
        drive(3, 1'b1, 1'b1, 1'b1, 32'h10, 32'h55555555);
        chk("abort_wait_rdy", 32'(bus3.pready), 32'h0);
        @(negedge pclk);
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            chk("abort_idle_rdy", 32'(bus3.pready), 32'h0);
        end
        xfer(3, 1'b0, 32'h10, 32'h0, "rd10_after_abort");

        xfer(0, 1'b1, 32'h6, 32'hDEADBEEF, "wr_misaligned");
        xfer(0, 1'b1, 32'h40, 32'hDEADBEEF, "wr_out_of_range");
        xfer(0, 1'b1, 32'h80000004, 32'hDEADBEEF, "wr_high_bit");
        xfer(0, 1'b0, 32'h40, 32'h0, "rd_out_of_range");
        xfer(0, 1'b0, 32'h4, 32'h0, "rd4_after_errs");

        xfer(0, 1'b1, 32'h8, 32'h89ABCDEF, "b2b_wr8_ws0");
        xfer(0, 1'b0, 32'h8, 32'h0, "b2b_rd8_ws0");
        xfer(3, 1'b1, 32'h3C, 32'h13572468, "b2b_wr3c_ws3");
        xfer(3, 1'b0, 32'h3C, 32'h0, "b2b_rd3c_ws3");
        xfer(0, 1'b0, 32'h0, 32'h0, "rd0_other_reg");

        // Reset lands on the completion edge of a write; the write must be lost.
        drive(0, 1'b1, 1'b0, 1'b1, 32'hC, 32'hA5A5A5A5);
        @(negedge pclk);
        drive(0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hA5A5A5A5);
        chk("rstacc_rdy", 32'(bus0.pready), 32'h1);
        rst = 1'b1;
        @(negedge pclk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge pclk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        clear_model();
        xfer(0, 1'b0, 32'hC, 32'h0, "rdC_after_reset");
        xfer(0, 1'b0, 32'h4, 32'h0, "rd4_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
